// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with stop-bit framing error flag
//
// Receives idle-high frames: one start bit (0), DATA_BITS data bits LSB first,
// one stop bit (1). The line is sampled on rx_en ticks (OVERSAMPLE per bit).
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-high reset
//   rx_en      oversample tick, one-cycle pulse at OVERSAMPLE x baud
//   rx         serial input, asynchronous to clk
//   data_out   last good received word, held until the next good frame
//   valid      one-cycle pulse when data_out is updated
//   busy       frame reception in progress (START, DATA, STOP)
//   frame_err  sticky: last frame had a stop bit of 0

module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [2:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_m;
    logic                 rx_s;

    // Two-flop synchronizer; both stages reset to the idle line level so a
    // reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign busy = (state == S_START) || (state == S_DATA) || (state == S_STOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // valid is a single-clock pulse, independent of the tick rate.
            valid <= 1'b0;
            if (rx_en) begin
                case (state)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state    <= S_START;
                            tick_cnt <= '0;
                        end
                    end
                    S_START: begin
                        // Half a bit after the falling edge: still low means a
                        // real start bit, high means a glitch.
                        if (tick_cnt == HALF_M1) begin
                            if (!rx_s) begin
                                state     <= S_DATA;
                                tick_cnt  <= '0;
                                bit_cnt   <= '0;
                                frame_err <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    S_DATA: begin
                        if (tick_cnt == FULL_M1) begin
                            // LSB arrives first, so shifting right leaves bit 0
                            // in shift_reg[0] after the last sample.
                            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                            tick_cnt  <= '0;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= S_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    S_STOP: begin
                        // Leaving at mid stop bit lets a back-to-back start edge
                        // be seen half a bit later.
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                data_out <= shift_reg;
                                valid    <= 1'b1;
                                state    <= S_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    S_BREAK: begin
                        // A line held low must return high before any new frame.
                        if (rx_s) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - table-driven self-checking bench for uart_rx

module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx_en;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_en     (rx_en),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    localparam int BIT_CLK = 64;
    // Busy spans 8 START ticks + 8*16 DATA ticks + 16 STOP ticks at 4 clk/tick.
    localparam int FRAME_BUSY_CLK = (8 + 128 + 16) * 4;
    // A rejected start bit holds busy for the 8 START ticks only.
    localparam int GLITCH_BUSY_CLK = 8 * 4;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_ticks;
        int         gap_bits;
        logic       use_tx;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[9];

    int applied;
    int fails;
    int valid_cnt;
    int busy_cycles;
    logic valid_prev;
    logic valid_wide;
    int   ph;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // rx_en every 4th clock, changed on the falling edge.
    initial begin
        rx_en = 1'b0;
        ph    = 0;
        forever begin
            @(negedge clk);
            ph    = (ph + 1) % 4;
            rx_en = (ph == 0);
        end
    end

    // Output monitor sampled on the falling edge.
    initial begin
        valid_cnt   = 0;
        busy_cycles = 0;
        valid_prev  = 1'b0;
        valid_wide  = 1'b0;
        forever begin
            @(negedge clk);
            if (valid) valid_cnt++;
            if (valid && valid_prev) valid_wide = 1'b1;
            valid_prev = valid;
            if (busy) busy_cycles++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        applied++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold_bits(input logic lvl, input int clks);
        rx = lvl;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_free(input logic [7:0] d, input logic stop);
        hold_bits(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) hold_bits(d[i], BIT_CLK);
        hold_bits(stop, BIT_CLK);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (n < 16) begin
            @(posedge clk);
            if (rx_en) break;
            n++;
        end
        if (n >= 16) check("tick_timeout", n, 0);
        @(negedge clk);
    endtask

    // Transmitter model advancing one bit every 16th rx_en tick.
    task automatic send_tx(input logic [7:0] d);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx = fr[b];
            for (int t = 0; t < 16; t++) wait_tick();
        end
    endtask

    task automatic run_vec(input int idx);
        int v0;
        v0          = valid_cnt;
        busy_cycles = 0;
        if (vecs[idx].use_tx) send_tx(vecs[idx].data);
        else send_free(vecs[idx].data, vecs[idx].stop);
        if (vecs[idx].low_ticks > 0) hold_bits(1'b0, vecs[idx].low_ticks * 4);
        hold_bits(1'b1, vecs[idx].gap_bits * BIT_CLK);
        check($sformatf("v%0d_valid_cnt", idx), valid_cnt - v0, int'(vecs[idx].exp_valid));
        check($sformatf("v%0d_data_out", idx), data_out, vecs[idx].exp_data);
        check($sformatf("v%0d_frame_err", idx), frame_err, vecs[idx].exp_ferr);
        check($sformatf("v%0d_busy_cycles", idx), busy_cycles, FRAME_BUSY_CLK);
    endtask

    initial begin
        int v0;
        applied = 0;
        fails   = 0;

        //             data  stop low gap  tx  valid exp   ferr
        vecs[0] = '{8'hA5, 1'b1, 0, 1, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 0, 0, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 0, 1, 1'b0, 1'b1, 8'hFF, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 0, 1, 1'b0, 1'b1, 8'h3C, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 40, 1, 1'b0, 1'b0, 8'h3C, 1'b1};
        vecs[5] = '{8'h42, 1'b1, 0, 1, 1'b0, 1'b1, 8'h42, 1'b0};
        vecs[6] = '{8'h5A, 1'b1, 0, 1, 1'b0, 1'b1, 8'h5A, 1'b0};
        vecs[7] = '{8'hC3, 1'b1, 0, 1, 1'b1, 1'b1, 8'hC3, 1'b0};
        vecs[8] = '{8'h18, 1'b1, 0, 1, 1'b1, 1'b1, 8'h18, 1'b0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data_out", data_out, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        hold_bits(1'b1, BIT_CLK);

        // Single frame, then back-to-back frames with no idle gap.
        for (int i = 0; i < 3; i++) run_vec(i);

        // Start-bit glitch: low for 3 ticks.
        v0          = valid_cnt;
        busy_cycles = 0;
        hold_bits(1'b0, 12);
        hold_bits(1'b1, 2 * BIT_CLK);
        check("glitch_busy_cycles", busy_cycles, GLITCH_BUSY_CLK);
        check("glitch_busy_now", busy, 0);
        check("glitch_valid_cnt", valid_cnt - v0, 0);
        check("glitch_frame_err", frame_err, 0);

        // Frame after glitch, framing error with held-low line, recovery frame.
        for (int i = 3; i < 6; i++) run_vec(i);

        // Reset in the middle of data bit 4 of 0x77.
        v0 = valid_cnt;
        hold_bits(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) hold_bits(1'(8'h77 >> i), BIT_CLK);
        hold_bits(1'b1, BIT_CLK / 2);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_data_out", data_out, 0);
        check("midrst_valid", valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_err", frame_err, 0);
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold_bits(1'b1, 4 * BIT_CLK);
        check("midrst_valid_cnt", valid_cnt - v0, 0);
        check("post_rst_data_out", data_out, 0);

        // Frame after reset, then tick-aligned loopback frames.
        for (int i = 6; i < 9; i++) run_vec(i);

        check("valid_single_cycle", int'(valid_wide), 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
        $finish;
    end

endmodule
